// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE result bus, aligns and extends
// sub-word SRAM load data, holds that data across WB back-pressure, and
// forwards the final result to WB and to ID for bypass.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  logic                       ms_valid;
  logic                       ms_first;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic [31:0]                rdata_buf;

  load_type_e  load_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic [1:0]  addr_lo;
  logic [31:0] rdata;
  logic [31:0] rdata_shifted;
  logic [15:0] rdata_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign load_type    = load_type_e'(es_to_ms_bus_r[73:71]);
  assign res_from_mem = es_to_ms_bus_r[70];
  assign gr_we        = es_to_ms_bus_r[69];
  assign dest         = es_to_ms_bus_r[68:64];
  assign result       = es_to_ms_bus_r[63:32];
  assign pc           = es_to_ms_bus_r[31:0];
  assign addr_lo      = result[1:0];

  // No internal stall source: the SRAM answers in a fixed single cycle.
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Occupancy, first-cycle marker and stall buffer for the SRAM read data.
  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every register samples pre-edge values
    // regardless of statement order.
    if (reset) begin
      ms_valid  <= 1'b0;
      ms_first  <= 1'b0;
      rdata_buf <= 32'h0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
        ms_first <= es_to_ms_valid;
      end else begin
        ms_first <= 1'b0;
      end
      if (ms_valid && ms_first) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  // Capture the EXE bus when a new instruction enters; hold it otherwise.
  always_ff @(posedge clk) begin
    // NOTE: the payload is deliberately left unreset; ms_valid qualifies it,
    // so clearing it would only cost reset fan-out.
    if (es_to_ms_valid && ms_allowin) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  // Live SRAM data only in the instruction's first cycle; buffered copy after.
  assign rdata         = ms_first ? data_sram_rdata : rdata_buf;
  assign rdata_shifted = rdata >> {addr_lo, 3'b000};
  assign rdata_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Sub-word extraction and extension by load type; unknown types act as ld.w.
  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no latch.
    load_data = rdata;
    case (load_type)
      LD_B:    load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      LD_H:    load_data = {{16{rdata_half[15]}}, rdata_half};
      LD_BU:   load_data = {24'h0, rdata_shifted[7:0]};
      LD_HU:   load_data = {16'h0, rdata_half};
      default: load_data = rdata;
    endcase
  end

  assign final_result = res_from_mem ? load_data : result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = {ms_valid && gr_we, dest, final_result, ms_valid};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a driver issues directed and random
// instructions and pushes the expected WB bus into a scoreboard; a monitor on
// the falling edge compares whatever the stage presents.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_to_ds_bus    (ms_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [69:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          vcount   = 0;
  bit          mon_en   = 1'b0;
  bit          pend_ok  = 1'b0;
  logic [31:0] pend_rdata = 32'h0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference load semantics expressed as plain shifts, masks and arithmetic.
  function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [73:0] mk_bus(input logic [2:0] lt, input logic rfm, input logic we,
                                         input logic [4:0] dest, input logic [31:0] res,
                                         input logic [31:0] pc);
    return {lt, rfm, we, dest, res, pc};
  endfunction

  function automatic logic [69:0] expect_of(input logic [73:0] bus, input logic [31:0] ld);
    logic [31:0] res;
    logic [31:0] fin;
    res = bus[63:32];
    fin = bus[70] ? load_value(bus[73:71], res[1:0], ld) : res;
    return {bus[69], bus[68:64], fin, bus[31:0]};
  endfunction

  // One clock of stimulus. `ld` is the SRAM word returned for this instruction
  // on the following cycle if it is accepted; `junk` is what the SRAM shows
  // on cycles that belong to nobody (e.g. EXE re-issuing while stalled).
  task automatic step(input logic v, input logic [73:0] bus, input logic [31:0] ld,
                      input logic ws, input logic [31:0] junk);
    es_to_ms_valid  = v;
    es_to_ms_bus    = bus;
    ws_allowin      = ws;
    data_sram_rdata = pend_ok ? pend_rdata : junk;
    @(posedge clk);
    pend_ok = 1'b0;
    if (reset) begin
      exp_q.delete();
    end else if (v && exp_q.size() == 0) begin
      exp_q.push_back(expect_of(bus, ld));
      pend_ok    = 1'b1;
      pend_rdata = ld;
    end
    #1;
  endtask

  task automatic idle(input logic ws);
    step(1'b0, {$urandom, $urandom, $urandom}, 32'h0, ws, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    check("drain", 70'(exp_q.size()), 70'd0);
  endtask

  task automatic rand_instr(output logic [73:0] bus);
    bus = mk_bus(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom),
                 $urandom, $urandom);
  endtask

  // Monitor: the scoreboard holds at most the single instruction in MEM.
  initial begin
    forever begin
      logic [69:0] e;
      bit          has;
      @(negedge clk);
      if (mon_en) begin
        has = exp_q.size() != 0;
        check("ws_valid", 70'(ms_to_ws_valid), 70'(has));
        check("allowin", 70'(ms_allowin), 70'(!has || ws_allowin));
        check("ds_valid", 70'(ms_to_ds_bus[0]), 70'(has));
        if (has) begin
          e = exp_q[0];
          check("ws_bus", ms_to_ws_bus, e);
          check("ds_bus", 70'(ms_to_ds_bus[38:1]), 70'({e[69], e[68:64], e[63:32]}));
          if (ws_allowin) void'(exp_q.pop_front());
        end else begin
          check("ds_we", 70'(ms_to_ds_bus[38]), 70'd0);
        end
        if (ms_to_ws_valid) vcount++;
      end
    end
  end

  initial begin
    logic [73:0] bus;

    reset = 1'b1;
    idle(1'b1);
    mon_en = 1'b1;
    idle(1'b1);
    reset = 1'b0;
    idle(1'b1);

    // ld.b of byte 3, sign bit set
    step(1'b1, mk_bus(3'd1, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h1c00_0000),
         32'h8000_0000, 1'b1, $urandom);
    idle(1'b1);
    // ld.hu / ld.h of the upper half
    step(1'b1, mk_bus(3'd4, 1'b1, 1'b1, 5'd4, 32'h0000_2002, 32'h1c00_0004),
         32'hBEEF_1234, 1'b1, $urandom);
    step(1'b1, mk_bus(3'd2, 1'b1, 1'b1, 5'd5, 32'h0000_2002, 32'h1c00_0008),
         32'hBEEF_1234, 1'b1, $urandom);
    idle(1'b1);
    drain();

    // ld.w held across a three-cycle WB stall while the SRAM output changes
    step(1'b1, mk_bus(3'd0, 1'b1, 1'b1, 5'd6, 32'h0000_3000, 32'h1c00_000c),
         32'h1234_5678, 1'b1, $urandom);
    step(1'b1, mk_bus(3'd0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0), 32'h0, 1'b0, 32'hDEAD_BEEF);
    step(1'b1, mk_bus(3'd0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0), 32'h0, 1'b0, 32'hDEAD_BEEF);
    step(1'b1, mk_bus(3'd0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0), 32'h0, 1'b0, 32'hDEAD_BEEF);
    idle(1'b1);
    drain();

    // ALU result passes through even with a load-type code present
    step(1'b1, mk_bus(3'd1, 1'b0, 1'b1, 5'd8, 32'hCAFE_F00D, 32'h1c00_0010),
         $urandom, 1'b1, $urandom);
    idle(1'b1);
    drain();

    // Eight back-to-back loads at full throughput
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      bus = mk_bus(3'($urandom_range(0, 4)), 1'b1, 1'b1, 5'(i + 1),
                   $urandom, 32'h1c00_0100 + 32'(4 * i));
      step(1'b1, bus, $urandom, 1'b1, $urandom);
    end
    idle(1'b1);
    check("b2b_count", 70'(vcount), 70'd8);
    drain();

    // Reset while stalled drops the held instruction
    step(1'b1, mk_bus(3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_4000, 32'h1c00_0200),
         32'h5555_AAAA, 1'b0, $urandom);
    idle(1'b0);
    idle(1'b0);
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
    idle(1'b0);
    // A fresh load after reset uses its own data, not stale buffered data
    step(1'b1, mk_bus(3'd3, 1'b1, 1'b1, 5'd10, 32'h0000_5001, 32'h1c00_0300),
         32'h0000_7F00, 1'b0, $urandom);
    idle(1'b0);
    idle(1'b1);
    drain();

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      rand_instr(bus);
      step(1'($urandom_range(0, 3) != 0), bus, $urandom, 1'($urandom_range(0, 2) != 0),
           $urandom);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
